// File: rtl/usb_rx_rcu.sv
// USB RX receiver control unit: gates the bit timer, checks SYNC/PID,
// pushes payload bytes to the RX FIFO and reports status to the endpoint.
module usb_rx_rcu #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 66
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       enable_timer,
    output logic       rcving,
    output logic       w_enable,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic       r_error,
    output logic [6:0] byte_count
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        CHECK_SYNC,
        PID_WAIT,
        CHECK_PID,
        DATA_WAIT,
        STORE,
        EOP_WAIT,
        ERR,
        ERR_EOP_WAIT,
        ERR_IDLE
    } state_t;

    state_t state;
    state_t next;
    logic   eop_s;
    logic   pid_ok;
    logic   start;

    assign eop_s  = eop & shift_enable;
    assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);

    always_comb begin
        next  = state;
        start = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_edge) begin
                    next  = SYNC_WAIT;
                    start = 1'b1;
                end
            end
            SYNC_WAIT: begin
                if (byte_received) next = CHECK_SYNC;
                else if (eop_s)    next = ERR;
            end
            CHECK_SYNC: begin
                next = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
            end
            PID_WAIT: begin
                if (byte_received) next = CHECK_PID;
                else if (eop_s)    next = ERR;
            end
            CHECK_PID: begin
                next = pid_ok ? DATA_WAIT : ERR;
            end
            // EOP wins over a coincident byte; a full packet turns the next byte into an error
            DATA_WAIT: begin
                if (eop_s) begin
                    next = EOP_WAIT;
                end else if (byte_received) begin
                    next = (byte_count == MAX_CNT) ? ERR : STORE;
                end
            end
            STORE: begin
                next = DATA_WAIT;
            end
            EOP_WAIT: begin
                if (d_edge) next = IDLE;
            end
            ERR: begin
                if (eop_s) next = ERR_EOP_WAIT;
            end
            ERR_EOP_WAIT: begin
                if (d_edge) next = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) begin
                    next  = SYNC_WAIT;
                    start = 1'b1;
                end
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            rx_pid     <= 4'h0;
            pid_valid  <= 1'b0;
            r_error    <= 1'b0;
            byte_count <= 7'd0;
        end else begin
            state <= next;
            if (start) begin
                r_error    <= 1'b0;
                pid_valid  <= 1'b0;
                byte_count <= 7'd0;
            end
            if (next == ERR && state != ERR) begin
                r_error <= 1'b1;
            end
            if (state == CHECK_PID && pid_ok) begin
                rx_pid    <= rcv_data[3:0];
                pid_valid <= 1'b1;
            end
            if (state == STORE && byte_count != MAX_CNT) begin
                byte_count <= byte_count + 7'd1;
            end
        end
    end

    assign w_enable = (state == STORE);

    assign rcving = (state != IDLE) && (state != ERR_IDLE);

    assign enable_timer = (state == SYNC_WAIT) || (state == CHECK_SYNC) ||
                          (state == PID_WAIT)  || (state == CHECK_PID)  ||
                          (state == DATA_WAIT) || (state == STORE)      ||
                          (state == ERR);

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Bench for usb_rx_rcu: packet-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_usb_rx_rcu;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       enable_timer;
    logic       rcving;
    logic       w_enable;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic       r_error;
    logic [6:0] byte_count;

    usb_rx_rcu #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .eop          (eop),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .rcv_data     (rcv_data),
        .enable_timer (enable_timer),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .rx_pid       (rx_pid),
        .pid_valid    (pid_valid),
        .r_error      (r_error),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int wcount = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Packet-level model: a packet is active from its opening edge to the
    // edge after EOP; each accepted byte costs one follow-up cycle.
    bit         m_act, m_eop, m_err, m_busy, m_wr, m_pidv;
    int         m_nb;
    logic [6:0] m_cnt;
    logic [3:0] m_pid;
    logic [7:0] m_pend;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_act = 0; m_eop = 0; m_err = 0; m_busy = 0; m_wr = 0;
            m_pidv = 0; m_nb = 0; m_cnt = 0; m_pid = 0; m_pend = 0;
        end else if (!m_act) begin
            if (d_edge) begin
                m_act = 1; m_eop = 0; m_err = 0; m_pidv = 0;
                m_cnt = 0; m_nb = 0; m_busy = 0; m_wr = 0;
            end
        end else if (m_eop) begin
            if (d_edge) m_act = 0;
        end else if (m_busy) begin
            m_busy = 0;
            if (m_wr) begin
                m_wr = 0;
                if (int'(m_cnt) < MAXB) m_cnt = m_cnt + 7'd1;
            end else if (m_nb == 1) begin
                if (m_pend != 8'h80) m_err = 1;
            end else if (m_pend[7:4] == ~m_pend[3:0]) begin
                m_pid  = m_pend[3:0];
                m_pidv = 1;
            end else begin
                m_err = 1;
            end
        end else if (m_err) begin
            if (eop && shift_enable) m_eop = 1;
        end else if (m_nb >= 2 && eop && shift_enable) begin
            m_eop = 1;
        end else if (byte_received) begin
            m_nb++;
            m_pend = rcv_data;
            if (m_nb <= 2) m_busy = 1;
            else if (int'(m_cnt) == MAXB) m_err = 1;
            else begin m_busy = 1; m_wr = 1; end
        end else if (eop && shift_enable) begin
            m_err = 1;
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            chk("rcving", 8'(rcving), 8'(m_act));
            chk("enable_timer", 8'(enable_timer), 8'(m_act && !m_eop));
            chk("w_enable", 8'(w_enable), 8'(m_wr));
            chk("r_error", 8'(r_error), 8'(m_err));
            chk("pid_valid", 8'(pid_valid), 8'(m_pidv));
            chk("rx_pid", 8'(rx_pid), 8'(m_pid));
            chk("byte_count", 8'(byte_count), 8'(m_cnt));
            if (w_enable) wcount++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
    endtask

    task automatic edge_p();
        d_edge = 1;
        step();
    endtask

    task automatic byte_p(input logic [7:0] b);
        step();
        step();
        rcv_data = b; shift_enable = 1; byte_received = 1;
        step();
    endtask

    task automatic eop_p();
        step();
        eop = 1; shift_enable = 1;
        step();
    endtask

    int w0;

    initial begin
        n_rst = 0; d_edge = 0; eop = 0; shift_enable = 0;
        byte_received = 0; rcv_data = 8'h00;
        repeat (3) step();
        n_rst = 1;
        step();
        chk("rst_rcving", 8'(rcving), 8'h0);
        chk("rst_timer", 8'(enable_timer), 8'h0);
        chk("rst_rx_pid", 8'(rx_pid), 8'h0);

        // bad PID
        w0 = wcount;
        edge_p(); byte_p(8'h80); byte_p(8'hC4); step(); step();
        chk("badpid_err", 8'(r_error), 8'h1);
        chk("badpid_pidv", 8'(pid_valid), 8'h0);
        chk("badpid_pid", 8'(rx_pid), 8'h0);
        chk("badpid_timer", 8'(enable_timer), 8'h1);
        eop_p(); edge_p();
        chk("badpid_rcving", 8'(rcving), 8'h0);
        chk("badpid_writes", 8'(wcount - w0), 8'h0);

        // good packet
        w0 = wcount;
        edge_p();
        chk("good_err_clr", 8'(r_error), 8'h0);
        byte_p(8'h80); byte_p(8'hC3);
        byte_p(8'h11); byte_p(8'h22); byte_p(8'h33); step();
        chk("good_pidv", 8'(pid_valid), 8'h1);
        chk("good_pid", 8'(rx_pid), 8'h3);
        chk("good_count", 8'(byte_count), 8'h3);
        eop_p();
        chk("good_timer_off", 8'(enable_timer), 8'h0);
        chk("good_rcving_eop", 8'(rcving), 8'h1);
        edge_p();
        chk("good_rcving_end", 8'(rcving), 8'h0);
        chk("good_writes", 8'(wcount - w0), 8'h3);
        chk("good_err", 8'(r_error), 8'h0);

        // bad SYNC
        w0 = wcount;
        edge_p(); byte_p(8'h81); step();
        chk("badsync_err", 8'(r_error), 8'h1);
        repeat (3) step();
        chk("badsync_timer", 8'(enable_timer), 8'h1);
        eop_p();
        chk("badsync_timer_off", 8'(enable_timer), 8'h0);
        edge_p();
        chk("badsync_rcving", 8'(rcving), 8'h0);
        chk("badsync_err_held", 8'(r_error), 8'h1);
        chk("badsync_writes", 8'(wcount - w0), 8'h0);

        // overflow
        edge_p();
        chk("ovf_err_clr", 8'(r_error), 8'h0);
        w0 = wcount;
        byte_p(8'h80); byte_p(8'h69);
        byte_p(8'h01); byte_p(8'h02); byte_p(8'h03); byte_p(8'h04); byte_p(8'h05);
        chk("ovf_err", 8'(r_error), 8'h1);
        chk("ovf_count", 8'(byte_count), 8'h4);
        chk("ovf_writes", 8'(wcount - w0), 8'h4);
        chk("ovf_pid", 8'(rx_pid), 8'h9);
        eop_p(); edge_p();

        // byte_received coincident with EOP
        w0 = wcount;
        edge_p(); byte_p(8'h80); byte_p(8'hC3); byte_p(8'h44); step();
        rcv_data = 8'h55; eop = 1; shift_enable = 1; byte_received = 1;
        step();
        chk("sim_rcving", 8'(rcving), 8'h1);
        chk("sim_timer", 8'(enable_timer), 8'h0);
        chk("sim_err", 8'(r_error), 8'h0);
        step(); step();
        chk("sim_writes", 8'(wcount - w0), 8'h1);
        chk("sim_count", 8'(byte_count), 8'h1);
        edge_p();
        chk("sim_end", 8'(rcving), 8'h0);

        // reset mid-packet
        edge_p(); byte_p(8'h80); byte_p(8'hC3); byte_p(8'hA1); byte_p(8'hA2); step();
        chk("mid_count", 8'(byte_count), 8'h2);
        #2 n_rst = 0;
        #1;
        chk("arst_rcving", 8'(rcving), 8'h0);
        chk("arst_timer", 8'(enable_timer), 8'h0);
        chk("arst_wen", 8'(w_enable), 8'h0);
        chk("arst_pid", 8'(rx_pid), 8'h0);
        chk("arst_pidv", 8'(pid_valid), 8'h0);
        chk("arst_err", 8'(r_error), 8'h0);
        chk("arst_count", 8'(byte_count), 8'h0);
        step(); step();
        n_rst = 1;
        step();
        w0 = wcount;
        edge_p(); byte_p(8'h80); byte_p(8'hC3); byte_p(8'h5A); step();
        eop_p(); edge_p();
        chk("post_count", 8'(byte_count), 8'h1);
        chk("post_writes", 8'(wcount - w0), 8'h1);
        chk("post_pid", 8'(rx_pid), 8'h3);

        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
